// File: rtl/cpucfg_issue_ctrl_if.sv
// cpucfg_issue_ctrl_if: request, table-lookup and writeback bundle for the CPUCFG issue controller
interface cpucfg_issue_ctrl_if #(
    parameter int TAG_W = 6
);
    logic             flush;
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_id;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_id;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      cpuconf_id;
    logic [31:0]      cpuconf_value;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;

    modport master (
        output flush, req0_valid, req0_id, req0_tag, req1_valid, req1_id, req1_tag,
        output cpuconf_value, wb_ready,
        input  req0_ready, req1_ready, cpuconf_id, wb_valid, wb_data, wb_tag
    );

    modport slave (
        input  flush, req0_valid, req0_id, req0_tag, req1_valid, req1_id, req1_tag,
        input  cpuconf_value, wb_ready,
        output req0_ready, req1_ready, cpuconf_id, wb_valid, wb_data, wb_tag
    );
endinterface

// File: rtl/cpucfg_issue_ctrl.sv
// cpucfg_issue_ctrl: round-robin CPUCFG server for two issue pipes with a small in-order result buffer
module cpucfg_issue_ctrl #(
    parameter int TAG_W     = 6,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cpucfg_issue_ctrl_if.slave bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rr_prio_q, rr_prio_d;
    logic [31:0]      data_q [BUF_DEPTH];
    logic [31:0]      data_d [BUF_DEPTH];
    logic [TAG_W-1:0] tag_q  [BUF_DEPTH];
    logic [TAG_W-1:0] tag_d  [BUF_DEPTH];
    logic             space, ready0, ready1, grant0, grant1, push, pop;
    logic [31:0]      gnt_id, result;
    logic [TAG_W-1:0] gnt_tag;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.wb_valid   = count_q != '0;
    assign bus.wb_data    = data_q[rd_ptr_q];
    assign bus.wb_tag     = tag_q[rd_ptr_q];

    // Arbitrate between the pipes and look up the winner; out-of-range indices read as zero
    always_comb begin
        space          = (count_q < DEPTH_C) && !bus.flush;
        ready0         = space && (!bus.req1_valid || !rr_prio_q);
        ready1         = space && (!bus.req0_valid || rr_prio_q);
        grant0         = bus.req0_valid && ready0;
        grant1         = bus.req1_valid && ready1;
        push           = grant0 || grant1;
        pop            = (count_q != '0) && bus.wb_ready && !bus.flush;
        gnt_id         = grant0 ? bus.req0_id : bus.req1_id;
        gnt_tag        = grant0 ? bus.req0_tag : bus.req1_tag;
        bus.cpuconf_id = push ? {27'b0, gnt_id[4:0]} : 32'h0;
        result         = (gnt_id[31:5] != 27'b0) ? 32'h0 : bus.cpuconf_value;
    end

    // Next state: buffer write, pointer/count update and priority flip; flush empties the buffer
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (push) begin
            data_d[wr_ptr_q] = result;
            tag_d[wr_ptr_q]  = gnt_tag;
        end
        rr_prio_d = grant0 ? 1'b1 : grant1 ? 1'b0 : rr_prio_q;
        wr_ptr_d  = bus.flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = bus.flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_prio_q <= 1'b0;
            data_q    <= '{default: '0};
            tag_q     <= '{default: '0};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_prio_q <= rr_prio_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
        end
    end
endmodule

// File: tb/tb_cpucfg_issue_ctrl.sv
// tb_cpucfg_issue_ctrl: directed self-checking bench for cpucfg_issue_ctrl
module tb_cpucfg_issue_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cpucfg_issue_ctrl_if #(.TAG_W(6)) bus ();

    cpucfg_issue_ctrl #(.TAG_W(6), .BUF_DEPTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Configuration table contents seen by the controller
    function automatic logic [31:0] tbl(input logic [31:0] idx);
        case (idx)
            32'd0:   return 32'h0014c010;
            32'd1:   return 32'h0001f1f4;
            32'd2:   return 32'h00000000;
            32'd16:  return 32'h00000005;
            32'd17:  return 32'h04080001;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    assign bus.cpuconf_value = tbl(bus.cpuconf_id);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_id    = 32'h0;
        bus.req0_tag   = 6'd0;
        bus.req1_valid = 1'b0;
        bus.req1_id    = 32'h0;
        bus.req1_tag   = 6'd0;
        bus.wb_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] loop_exp [3];

    initial begin
        checks   = 0;
        failures = 0;
        loop_exp[0] = 32'h0014c010;
        loop_exp[1] = 32'h0001f1f4;
        loop_exp[2] = 32'h00000000;
        rst_n    = 1'b1;
        idle();
        #2;
        rst_n = 1'b0;
        tick();
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_wb_tag", 32'(bus.wb_tag), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd1;
        bus.req0_tag   = 6'd5;
        bus.wb_ready   = 1'b1;
        #1;
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t1_cpuconf_id", bus.cpuconf_id, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t1_wb_data", bus.wb_data, 32'h0001f1f4);
        chk("t1_wb_tag", 32'(bus.wb_tag), 32'd5);
        tick();
        chk("t1_drained", 32'(bus.wb_valid), 32'd0);

        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd16;
        bus.req0_tag   = 6'd1;
        bus.req1_valid = 1'b1;
        bus.req1_id    = 32'd17;
        bus.req1_tag   = 6'd2;
        #1;
        chk("t2_c1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t2_c1_ready1", 32'(bus.req1_ready), 32'd0);
        chk("t2_c1_id", bus.cpuconf_id, 32'd16);
        tick();
        chk("t2_c2_ready0", 32'(bus.req0_ready), 32'd0);
        chk("t2_c2_ready1", 32'(bus.req1_ready), 32'd1);
        chk("t2_c2_id", bus.cpuconf_id, 32'd17);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("t2_first_data", bus.wb_data, 32'h00000005);
        chk("t2_first_tag", 32'(bus.wb_tag), 32'd1);
        bus.wb_ready = 1'b1;
        tick();
        chk("t2_second_data", bus.wb_data, 32'h04080001);
        chk("t2_second_tag", 32'(bus.wb_tag), 32'd2);
        tick();
        chk("t2_drained", 32'(bus.wb_valid), 32'd0);

        bus.req1_valid = 1'b1;
        bus.req1_id    = 32'h00000021;
        bus.req1_tag   = 6'd9;
        #1;
        chk("t3_cpuconf_id", bus.cpuconf_id, 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("t3_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("t3_wb_data", bus.wb_data, 32'h0);
        chk("t3_wb_tag", 32'(bus.wb_tag), 32'd9);
        tick();

        bus.wb_ready   = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd0;
        bus.req0_tag   = 6'd10;
        #1;
        chk("t4_ready_a", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_id  = 32'd1;
        bus.req0_tag = 6'd11;
        #1;
        chk("t4_ready_b", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_id  = 32'd2;
        bus.req0_tag = 6'd12;
        #1;
        chk("t4_full_ready", 32'(bus.req0_ready), 32'd0);
        tick();
        chk("t4_hold_data", bus.wb_data, 32'h0014c010);
        chk("t4_hold_tag", 32'(bus.wb_tag), 32'd10);
        bus.wb_ready = 1'b1;
        #1;
        chk("t4_no_bypass", 32'(bus.req0_ready), 32'd0);
        tick();
        chk("t4_ready_after_pop", 32'(bus.req0_ready), 32'd1);
        chk("t4_second_data", bus.wb_data, 32'h0001f1f4);
        chk("t4_second_tag", 32'(bus.wb_tag), 32'd11);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t4_third_tag", 32'(bus.wb_tag), 32'd12);
        chk("t4_third_data", bus.wb_data, 32'h0);
        tick();
        chk("t4_empty", 32'(bus.wb_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_id    = 32'(i % 3);
            bus.req0_tag   = 6'(20 + i);
            #1;
            chk("t4_stream_ready", 32'(bus.req0_ready), 32'd1);
            tick();
            chk("t4_stream_valid", 32'(bus.wb_valid), 32'd1);
            chk("t4_stream_tag", 32'(bus.wb_tag), 32'(20 + i));
            chk("t4_stream_data", bus.wb_data, loop_exp[i % 3]);
        end
        bus.req0_valid = 1'b0;
        tick();
        chk("t4_stream_drained", 32'(bus.wb_valid), 32'd0);

        bus.wb_ready   = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd16;
        bus.req0_tag   = 6'd3;
        tick();
        bus.req0_id  = 32'd17;
        bus.req0_tag = 6'd4;
        tick();
        bus.req0_id  = 32'd1;
        bus.req0_tag = 6'd6;
        bus.wb_ready = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("t5_flush_ready", 32'(bus.req0_ready), 32'd0);
        chk("t5_flush_cpuconf_id", bus.cpuconf_id, 32'd0);
        tick();
        bus.flush      = 1'b0;
        bus.req0_valid = 1'b0;
        #1;
        chk("t5_after_flush_valid", 32'(bus.wb_valid), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd2;
        bus.req0_tag   = 6'd7;
        #1;
        chk("t5_new_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t5_new_valid", 32'(bus.wb_valid), 32'd1);
        chk("t5_new_data", bus.wb_data, 32'h0);
        chk("t5_new_tag", 32'(bus.wb_tag), 32'd7);
        tick();

        bus.wb_ready   = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd1;
        bus.req0_tag   = 6'd8;
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t6_pre_valid", 32'(bus.wb_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.wb_valid), 32'd0);
        chk("t6_async_data", bus.wb_data, 32'h0);
        chk("t6_async_tag", 32'(bus.wb_tag), 32'd0);
        tick();
        rst_n          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_id    = 32'd16;
        bus.req0_tag   = 6'd13;
        bus.req1_valid = 1'b1;
        bus.req1_id    = 32'd17;
        bus.req1_tag   = 6'd14;
        #1;
        chk("t6_grant0_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t6_grant0_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("t6_wb_tag", 32'(bus.wb_tag), 32'd13);
        chk("t6_wb_data", bus.wb_data, 32'h00000005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpucfg_issue_ctrl.md
Name: cpucfg_issue_ctrl

Overview:
- Back-end controller that serves CPUCFG instructions from two issue pipes using one shared configuration lookup table.
- Round-robin arbitrates between the two requesters and drives the table's word index.
- Captures the looked-up word into a small result buffer.
- Returns results with their tags on a valid/ready writeback port; a pipeline flush discards everything in flight.

Parameters:
- TAG_W, 6: width of the ROB/destination tag carried with each request.
- BUF_DEPTH, 2: number of result-buffer entries; a power of two, ≥2.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous reset, active-low.
- flush, input, 1: pipeline flush; discards buffered results.
- req0_valid, input, 1: pipe-0 CPUCFG request valid.
- req0_ready, output, 1: pipe-0 request accepted this cycle.
- req0_id, input, 32: pipe-0 CPUCFG word index (rj value).
- req0_tag, input, TAG_W: pipe-0 tag.
- req1_valid, input, 1: pipe-1 CPUCFG request valid.
- req1_ready, output, 1: pipe-1 request accepted this cycle.
- req1_id, input, 32: pipe-1 CPUCFG word index.
- req1_tag, input, TAG_W: pipe-1 tag.
- cpuconf_id, output, 32: index driven to the shared configuration table.
- cpuconf_value, input, 32: combinational table output for cpuconf_id.
- wb_valid, output, 1: result available.
- wb_ready, input, 1: writeback consumer accepts the result.
- wb_data, output, 32: CPUCFG result word.
- wb_tag, output, TAG_W: tag of the result.

Behaviour:
Reset (asynchronous, while rst_n=0):
- count=0, rd/wr pointers=0, all buffer entries' data and tag=0.
- rr_prio=0; wb_valid=0, wb_data=0, wb_tag=0.

Space and ready:
- space = (count < BUF_DEPTH) & !flush.
- No same-cycle pop-to-push bypass: a full buffer deasserts ready even when wb_ready=1.
- reqN_ready = space & (!req_other_valid | rr_prio==N).
- Ready may depend combinationally on the other pipe's valid. At most one grant per cycle.

Grant:
- Accept occurs when reqN_valid & reqN_ready.
- On any accept, rr_prio ← the non-granted index. A lone requester still flips rr_prio.
- cpuconf_id = the granted request's id, {27'b0, id[4:0]}; 32'h0 when no grant.

Result computation:
- result = (id[31:5] != 0) ? 32'h0 : cpuconf_value.
- Out-of-range indices return zero and are never aliased onto low table entries.

Buffer:
- On accept, {result, tag} is written at wr_ptr; wr_ptr increments modulo BUF_DEPTH (wraps).
- Latency: a request accepted in cycle T appears on wb in cycle T+1 at the earliest.
- wb_valid = (count != 0). wb_data and wb_tag come from the rd_ptr entry, registered storage with no combinational path from req inputs.
- Pop on wb_valid & wb_ready: rd_ptr increments modulo BUF_DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Results leave in acceptance order. wb_data and wb_tag are held stable while wb_valid=1 and wb_ready=0.

Flush:
- In the flush cycle: no accept, and a pop is ignored.
- Next edge: count=0, rd_ptr=wr_ptr=0.
- Entry contents are not cleared, but wb_valid=0 from the next cycle. rr_prio is unchanged.

Reset mid-operation: immediate return to reset values; pending results are lost.

Test Plan:
1. Single request: req0 id=1, tag=5, wb_ready=1 → cpuconf_id=1 in the accept cycle; next cycle wb_valid=1, wb_data=32'h1f1f4, wb_tag=5; count returns to 0.
2. Contention: both pipes valid (id0=16/tag 1, id1=17/tag 2) for two cycles from reset → cycle 1 grants req0, cycle 2 grants req1; wb order is 32'h5/tag 1, then 32'h04080001/tag 2.
3. Out of range: req1 id=32'h00000021 while the table returns non-zero for index 1 → cpuconf_id=1, wb_data=32'h0.
4. Backpressure and wrap: wb_ready=0, three back-to-back req0 (ids 0, 1, 2) → two accepted, ready low on the third until wb_ready=1. Then continuous traffic for 6 results → all pointer wraps stay in order and count never exceeds 2.
5. Flush: buffer holds 2 results, flush=1 together with req0_valid and wb_ready → no accept and no pop; next cycle wb_valid=0, and a new req0 id=2 returns 32'h0 after one cycle.
6. Async reset: assert rst_n=0 mid-cycle with count=1 → wb_valid falls immediately without waiting for a clock edge; after release the first grant under contention goes to req0.
